// File: rtl/ct_ebiu_lpctl.sv
`default_nettype none
// ============================================================================
// Module   : ct_ebiu_lpctl
// Brief    : AXI low-power (csysreq/csysack/cactive) controller for the EBIU
//            master port. Drains or holds EBIU traffic, then accepts (or,
//            with EBIU_LP_DENY_EN defined, denies) the low-power request.
// Revision : 1.0 - initial release
// ============================================================================
module ct_ebiu_lpctl #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_THRESH  = 8,
  parameter int DENY_TIMEOUT = 64
) (
  input  logic       forever_cpuclk_i,
  input  logic       cpurst_b_i,
  input  logic       clk_en_i,
  input  logic       pad_ebiu_csysreq_i,
  input  logic       ebiu_xx_no_op_i,
  input  logic       ebiu_lp_wake_req_i,
  output logic       ebiu_pad_csysack_o,
  output logic       ebiu_pad_cactive_o,
  output logic       ebiu_lp_hold_o,
  output logic [1:0] ebiu_lp_state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_LP    = 2'b10,
    ST_DENY  = 2'b11
  } lp_state_e;

  localparam logic [3:0] c_idle_thresh = 4'(IDLE_THRESH);

  if (SYNC_STAGES < 2 || IDLE_THRESH < 1 || IDLE_THRESH > 15 ||
      DENY_TIMEOUT < 1 || DENY_TIMEOUT > 255) begin : g_bad_params
    $error("ct_ebiu_lpctl: parameter out of range");
  end

  // Request synchronizer runs on every clock so the request is never lost
  // while the bus-ratio enable is low.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_req_s;

  always_ff @(posedge forever_cpuclk_i or negedge cpurst_b_i) begin
    if (!cpurst_b_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_ebiu_csysreq_i};
    end
  end

  assign w_req_s = sync_q[SYNC_STAGES-1];

  logic [3:0] idle_cnt_q;
  logic [3:0] idle_cnt_d;
  logic       w_idle_cactive;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!ebiu_xx_no_op_i) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != c_idle_thresh) begin
      idle_cnt_d = idle_cnt_q + 4'd1;
    end
  end

  assign w_idle_cactive = (idle_cnt_d != c_idle_thresh);

`ifdef EBIU_LP_DENY_EN
  localparam logic [7:0] c_deny_last = 8'(DENY_TIMEOUT - 1);
  logic [7:0] deny_cnt_q;
`endif

  lp_state_e state_q;
  logic      csysack_q;
  logic      cactive_q;
  logic      hold_q;

  always_ff @(posedge forever_cpuclk_i or negedge cpurst_b_i) begin
    if (!cpurst_b_i) begin
      state_q    <= ST_RUN;
      csysack_q  <= 1'b1;
      cactive_q  <= 1'b1;
      hold_q     <= 1'b0;
      idle_cnt_q <= '0;
`ifdef EBIU_LP_DENY_EN
      deny_cnt_q <= '0;
`endif
    end else if (clk_en_i) begin
      idle_cnt_q <= idle_cnt_d;
      case (state_q)
        ST_RUN: begin
          if (!w_req_s) begin
            state_q   <= ST_DRAIN;
            hold_q    <= 1'b1;
            cactive_q <= 1'b1;
`ifdef EBIU_LP_DENY_EN
            deny_cnt_q <= '0;
`endif
          end else begin
            cactive_q <= w_idle_cactive;
          end
        end
        ST_DRAIN: begin
          // A withdrawn request beats a simultaneous idle: no ack is issued.
          if (w_req_s) begin
            state_q   <= ST_RUN;
            hold_q    <= 1'b0;
            cactive_q <= 1'b1;
          end else if (ebiu_xx_no_op_i) begin
            state_q   <= ST_LP;
            csysack_q <= 1'b0;
            cactive_q <= 1'b0;
          end
`ifdef EBIU_LP_DENY_EN
          else if (deny_cnt_q == c_deny_last) begin
            state_q   <= ST_DENY;
            csysack_q <= 1'b0;
            cactive_q <= 1'b1;
            hold_q    <= 1'b0;
          end else begin
            deny_cnt_q <= deny_cnt_q + 8'd1;
          end
`endif
        end
        ST_LP: begin
          if (w_req_s) begin
            state_q   <= ST_RUN;
            csysack_q <= 1'b1;
            cactive_q <= 1'b1;
            hold_q    <= 1'b0;
          end else if (ebiu_lp_wake_req_i) begin
            cactive_q <= 1'b1;
          end
        end
`ifdef EBIU_LP_DENY_EN
        ST_DENY: begin
          if (w_req_s) begin
            state_q   <= ST_RUN;
            csysack_q <= 1'b1;
            cactive_q <= 1'b1;
            hold_q    <= 1'b0;
          end
        end
`endif
        default: begin
          state_q   <= ST_RUN;
          csysack_q <= 1'b1;
          cactive_q <= 1'b1;
          hold_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ebiu_pad_csysack_o = csysack_q;
  assign ebiu_pad_cactive_o = cactive_q;
  assign ebiu_lp_hold_o     = hold_q;
  assign ebiu_lp_state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_ebiu_lpctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_ebiu_lpctl
// Brief    : Directed bench for ct_ebiu_lpctl with a protocol-level model
//            compared on every negative clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_ebiu_lpctl;

  localparam int SYNC_STAGES  = 2;
  localparam int IDLE_THRESH  = 8;
  localparam int DENY_TIMEOUT = 64;
`ifdef EBIU_LP_DENY_EN
  localparam bit DENY_EN = 1'b1;
`else
  localparam bit DENY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       csysreq = 1'b1;
  logic       no_op = 1'b0;
  logic       wake = 1'b0;
  logic       ack;
  logic       cact;
  logic       hold;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  bit half = 1'b0;

  always #5 clk = ~clk;

  ct_ebiu_lpctl #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_THRESH (IDLE_THRESH),
    .DENY_TIMEOUT(DENY_TIMEOUT)
  ) dut (
    .forever_cpuclk_i  (clk),
    .cpurst_b_i        (rst_n),
    .clk_en_i          (clk_en),
    .pad_ebiu_csysreq_i(csysreq),
    .ebiu_xx_no_op_i   (no_op),
    .ebiu_lp_wake_req_i(wake),
    .ebiu_pad_csysack_o(ack),
    .ebiu_pad_cactive_o(cact),
    .ebiu_lp_hold_o    (hold),
    .ebiu_lp_state_o   (state)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Protocol model: mode 0 run, 1 draining, 2 low power, 3 denied.
  bit rq[$];
  int m_mode, m_prev, idle_run, drain_len;
  bit woke, req;
  bit e_ack, e_cact, e_hold;
  int e_state;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.delete();
      for (int i = 0; i < SYNC_STAGES; i++) rq.push_back(1'b1);
      m_mode = 0; idle_run = 0; drain_len = 0; woke = 0;
      e_ack = 1; e_cact = 1; e_hold = 0; e_state = 0;
    end else begin
      req = rq.pop_front();
      rq.push_back(csysreq);
      if (clk_en) begin
        m_prev = m_mode;
        if (!no_op) idle_run = 0;
        else if (idle_run < IDLE_THRESH) idle_run++;
        case (m_mode)
          0: if (!req) begin m_mode = 1; drain_len = 0; end
          1: begin
            if (req) m_mode = 0;
            else if (no_op) begin m_mode = 2; woke = 0; end
            else begin
              drain_len++;
              if (DENY_EN && drain_len == DENY_TIMEOUT) m_mode = 3;
            end
          end
          2: if (req) m_mode = 0; else if (wake) woke = 1;
          default: if (req) m_mode = 0;
        endcase
        e_state = m_mode;
        e_ack   = (m_mode == 0 || m_mode == 1);
        e_hold  = (m_mode == 1 || m_mode == 2);
        case (m_mode)
          0: e_cact = (m_prev != 0) ? 1'b1 : (idle_run != IDLE_THRESH);
          2: e_cact = woke;
          default: e_cact = 1'b1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("model_ack", ack, e_ack);
    chk("model_cactive", cact, e_cact);
    chk("model_hold", hold, e_hold);
    chk("model_state", state, e_state);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (half) clk_en = ~clk_en;
    end
  endtask

  initial begin
    @(negedge clk);
    chk("reset_ack", ack, 1);
    chk("reset_cactive", cact, 1);
    chk("reset_hold", hold, 0);
    chk("reset_state", state, 0);
    rst_n = 1'b1;

    // T1: idle count drops cactive after IDLE_THRESH idle cycles
    no_op = 1'b1;
    tick(7);
    chk("t1_cact_before", cact, 1);
    chk("t1_ack", ack, 1);
    tick(1);
    chk("t1_cact_drop", cact, 0);
    no_op = 1'b0;
    tick(1);
    chk("t1_cact_rise", cact, 1);

    // T2: accept path latency
    no_op = 1'b1; csysreq = 1'b0;
    tick(2);
    chk("t2_sync_state", state, 0);
    tick(1);
    chk("t2_drain_state", state, 1);
    chk("t2_drain_hold", hold, 1);
    chk("t2_drain_ack", ack, 1);
    tick(1);
    chk("t2_lp_state", state, 2);
    chk("t2_lp_ack", ack, 0);
    chk("t2_lp_cact", cact, 0);
    csysreq = 1'b1;
    tick(2);
    chk("t2_exit_wait_ack", ack, 0);
    tick(1);
    chk("t2_exit_ack", ack, 1);
    chk("t2_exit_hold", hold, 0);
    chk("t2_exit_cact", cact, 1);

    // T3: busy bus holds off the ack
    no_op = 1'b0; csysreq = 1'b0;
    tick(3);
    chk("t3_drain_state", state, 1);
    tick(20);
    chk("t3_still_drain", state, 1);
    chk("t3_hold", hold, 1);
    chk("t3_ack", ack, 1);
    no_op = 1'b1;
    tick(1);
    chk("t3_ack_drop", ack, 0);
    chk("t3_lp_state", state, 2);

    // T4: wake request makes cactive sticky in LP
    wake = 1'b1;
    tick(1);
    chk("t4_wake_cact", cact, 1);
    wake = 1'b0;
    tick(3);
    chk("t4_sticky_cact", cact, 1);
    chk("t4_ack_low", ack, 0);
    csysreq = 1'b1;
    tick(3);
    chk("t4_run_ack", ack, 1);
    chk("t4_run_state", state, 0);

    // T5: half-rate enable, accept then abort
    half = 1'b1;
    no_op = 1'b1; csysreq = 1'b0;
    tick(12);
    chk("t5_lp_state", state, 2);
    chk("t5_lp_ack", ack, 0);
    csysreq = 1'b1;
    tick(12);
    chk("t5_run_state", state, 0);
    no_op = 1'b0; csysreq = 1'b0;
    tick(8);
    chk("t5_drain_state", state, 1);
    chk("t5_drain_ack", ack, 1);
    csysreq = 1'b1;
    tick(8);
    chk("t5_abort_state", state, 0);
    chk("t5_abort_hold", hold, 0);
    chk("t5_abort_ack", ack, 1);
    half = 1'b0;
    clk_en = 1'b1;

    // T6: permanently busy bus
    no_op = 1'b0; csysreq = 1'b0;
    tick(66);
    chk("t6_pre_state", state, 1);
    tick(1);
    chk("t6_state", state, DENY_EN ? 3 : 1);
    chk("t6_ack", ack, DENY_EN ? 0 : 1);
    chk("t6_hold", hold, DENY_EN ? 0 : 1);
    chk("t6_cact", cact, 1);
    csysreq = 1'b1;
    tick(3);
    chk("t6_exit_ack", ack, 1);
    chk("t6_exit_state", state, 0);

    // Asynchronous reset while in LP
    no_op = 1'b1; csysreq = 1'b0;
    tick(5);
    chk("rst_lp_state", state, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_ack", ack, 1);
    chk("rst_async_hold", hold, 0);
    chk("rst_async_state", state, 0);
    chk("rst_async_cact", cact, 1);
    csysreq = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("rst_after_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
